reg_bank_serial_reader: RTL



---
 rtl/reg_bank_serial_reader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reg_bank_serial_reader.sv
// Reads a run of consecutive words from a synchronous-read register bank and
// streams each word MSB-first over a bit-serial valid/ready link.
module reg_bank_serial_reader #(
  parameter int DATA_W  = 16,
  parameter int N_WORDS = 4,
  parameter int ADDR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W:0]     words_left;
  logic [ADDR_W:0]     len_clamped;
  logic [DATA_W-1:0]   shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic                xfer;
  logic                word_end;

  // Requests longer than the bank are truncated to one full pass.
  assign len_clamped = (len > (ADDR_W+1)'(N_WORDS)) ? (ADDR_W+1)'(N_WORDS) : len;
  assign xfer        = (state == S_SHIFT) && ser_ready;
  assign word_end    = (bit_cnt == '0);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr   <= '0;
      words_left <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr   <= addr;
            words_left <= len_clamped;
          end
        end
        S_WAIT: begin
          shift_reg  <= rd_data;
          bit_cnt    <= CNT_W'(DATA_W - 1);
          // N_WORDS is a power of two, so natural overflow wraps to word 0.
          cur_addr   <= cur_addr + ADDR_W'(1);
          words_left <= words_left - (ADDR_W+1)'(1);
        end
        S_SHIFT: begin
          if (ser_ready) begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (len_clamped == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        rd_en     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: state_nxt = S_SHIFT;
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = shift_reg[DATA_W-1];
        ser_last  = word_end && (words_left == '0);
        if (xfer && word_end) state_nxt = (words_left != '0) ? S_FETCH : S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_addr = cur_addr;

endmodule
